// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit: one op in flight, request/grant memory bus, wait timeout.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_we,
  input  logic [2:0]  op_funct3,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic [31:0] ld_data,
  output logic        err_align,
  output logic        err_bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state, state_nx;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [7:0]  cnt, cnt_nx;
  logic [31:0] ld_q, ld_nx;
  logic        ea_q, ea_nx, eb_q, eb_nx;
  logic        accept, op_legal, op_misaligned, op_bad;
  logic [31:0] rdata_shift, ld_ext;
  logic [3:0]  be;
  logic [7:0]  cnt_inc;

  assign accept = op_valid && (state == IDLE);

  // Legality is judged on the live inputs so a bad op can go straight to DONE.
  always_comb begin
    op_legal = 1'b0;
    if (op_we) begin
      op_legal = (op_funct3 == 3'b000) || (op_funct3 == 3'b001) || (op_funct3 == 3'b010);
    end else begin
      op_legal = (op_funct3 == 3'b000) || (op_funct3 == 3'b001) || (op_funct3 == 3'b010) ||
                 (op_funct3 == 3'b100) || (op_funct3 == 3'b101);
    end
    op_misaligned = ((op_funct3[1:0] == 2'b01) && op_addr[0]) ||
                    ((op_funct3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
    op_bad = !op_legal || op_misaligned;
  end

  always_comb begin
    be = 4'b1111;
    mem_wdata = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be = 4'b0001 << addr_q[1:0];
        mem_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be = 4'b0011 << addr_q[1:0];
        mem_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        be = 4'b1111;
        mem_wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    rdata_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b100:  ld_ext = {24'h0, rdata_shift[7:0]};
      3'b001:  ld_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b101:  ld_ext = {16'h0, rdata_shift[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  assign cnt_inc = cnt + 8'd1;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ld_nx    = ld_q;
    ea_nx    = ea_q;
    eb_nx    = eb_q;
    case (state)
      IDLE: begin
        ld_nx = 32'h0;
        ea_nx = 1'b0;
        eb_nx = 1'b0;
        if (op_valid) begin
          cnt_nx = 8'h0;
          if (op_bad) begin
            state_nx = DONE;
            ea_nx    = 1'b1;
          end else begin
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        // A simultaneous rvalid is ignored here; the response must follow the grant.
        if (mem_gnt) begin
          cnt_nx   = 8'h0;
          state_nx = we_q ? DONE : RESP;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          state_nx = DONE;
          eb_nx    = 1'b1;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          ld_nx    = ld_ext;
          state_nx = DONE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          state_nx = DONE;
          eb_nx    = 1'b1;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      DONE: begin
        state_nx = IDLE;
        ld_nx    = 32'h0;
        ea_nx    = 1'b0;
        eb_nx    = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'h0;
      ld_q    <= 32'h0;
      ea_q    <= 1'b0;
      eb_q    <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ld_q  <= ld_nx;
      ea_q  <= ea_nx;
      eb_q  <= eb_nx;
      if (accept) begin
        we_q    <= op_we;
        f3_q    <= op_funct3;
        addr_q  <= op_addr;
        wdata_q <= op_wdata;
      end
    end
  end

  assign op_ready  = (state == IDLE);
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_be    = mem_req ? be : 4'b0000;
  assign done      = (state == DONE);
  assign ld_data   = done ? ld_q : 32'h0;
  assign err_align = done && ea_q;
  assign err_bus   = done && eb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - table-driven bench for load_store_unit with TIMEOUT=4.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, op_ready, op_we;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata;
  logic        mem_req, mem_gnt, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        done;
  logic [31:0] ld_data;
  logic        err_align, err_bus;

  int n_cmp = 0;
  int n_fail = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_we(op_we), .op_funct3(op_funct3),
    .op_addr(op_addr), .op_wdata(op_wdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .done(done), .ld_data(ld_data), .err_align(err_align), .err_bus(err_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;
    logic        rv;
    logic        both;
    int          lat;
    int          reqs;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] maddr;
    logic        mwe;
    logic [31:0] ld;
    logic        ea;
    logic        eb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input int idx, input vec_t v);
    int lat, reqs;
    logic fin, granted, pend, leak, unstable;
    logic [3:0] be_c;
    logic [31:0] wd_c, ad_c, ld_c;
    logic we_c, ea_c, eb_c;
    lat = 0; reqs = 0; fin = 0; pend = 0; leak = 0; unstable = 0;
    be_c = 0; wd_c = 0; ad_c = 0; we_c = 0; ld_c = 0; ea_c = 0; eb_c = 0;
    @(negedge clk);
    check($sformatf("v%0d_ready", idx), {31'h0, op_ready}, 32'h1);
    op_valid = 1'b1; op_we = v.we; op_funct3 = v.f3; op_addr = v.addr; op_wdata = v.wdata;
    @(posedge clk);
    #1;
    op_valid = 1'b0; op_we = ~v.we; op_funct3 = ~v.f3; op_addr = ~v.addr; op_wdata = ~v.wdata;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      lat++;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      granted = 1'b0;
      if (done) begin
        fin = 1'b1;
        ld_c = ld_data; ea_c = err_align; eb_c = err_bus;
        if (op_ready) leak = 1'b1;
      end else begin
        if (err_align || err_bus || (ld_data != 32'h0) || op_ready) leak = 1'b1;
        if (mem_req) begin
          reqs++;
          if (reqs == 1) begin
            be_c = mem_be; wd_c = mem_wdata; ad_c = mem_addr; we_c = mem_we;
          end else if (be_c != mem_be || wd_c != mem_wdata || ad_c != mem_addr || we_c != mem_we) begin
            unstable = 1'b1;
          end
          if (reqs == v.gnt_dly + 1) begin
            mem_gnt = 1'b1; granted = 1'b1;
          end
          if (v.both) mem_rvalid = 1'b1;
        end else if (pend && v.rv) begin
          mem_rvalid = 1'b1; mem_rdata = v.rdata;
        end
        pend = granted && !v.we;
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (!fin) begin
      n_cmp++; n_fail++;
      $display("FAIL v%0d_timeout: no done within 40 cycles", idx);
    end else begin
      check($sformatf("v%0d_lat", idx), lat, v.lat);
      check($sformatf("v%0d_reqs", idx), reqs, v.reqs);
      check($sformatf("v%0d_be", idx), {28'h0, be_c}, {28'h0, v.be});
      check($sformatf("v%0d_mwdata", idx), wd_c, v.mwdata);
      check($sformatf("v%0d_maddr", idx), ad_c, v.maddr);
      check($sformatf("v%0d_mwe", idx), {31'h0, we_c}, {31'h0, v.mwe});
      check($sformatf("v%0d_ld", idx), ld_c, v.ld);
      check($sformatf("v%0d_err_align", idx), {31'h0, ea_c}, {31'h0, v.ea});
      check($sformatf("v%0d_err_bus", idx), {31'h0, eb_c}, {31'h0, v.eb});
      check($sformatf("v%0d_stable_noleak", idx), {30'h0, unstable, leak}, 32'h0);
    end
  endtask

  initial begin
    //             we  f3      addr          wdata         rdata        gdly rv both lat reqs be       mwdata        maddr         mwe ld            ea eb
    vecs.push_back('{0, 3'b000, 32'h0000_1003, 32'h0,        32'h8011_2233, 0, 1, 0, 3, 1, 4'b1000, 32'h0,        32'h0000_1000, 0, 32'hFFFF_FF80, 0, 0});
    vecs.push_back('{0, 3'b100, 32'h0000_1003, 32'h0,        32'h8011_2233, 0, 1, 0, 3, 1, 4'b1000, 32'h0,        32'h0000_1000, 0, 32'h0000_0080, 0, 0});
    vecs.push_back('{1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0,       0, 1, 0, 2, 1, 4'b1100, 32'hABCD_ABCD, 32'h0000_2000, 1, 32'h0,         0, 0});
    vecs.push_back('{0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,        0, 1, 0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 32'h0,         1, 0});
    vecs.push_back('{0, 3'b011, 32'h0000_3000, 32'h0,        32'h0,        0, 1, 0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 32'h0,         1, 0});
    vecs.push_back('{0, 3'b001, 32'h0000_5002, 32'h0,        32'h8001_1234, 0, 1, 0, 3, 1, 4'b1100, 32'h0,        32'h0000_5000, 0, 32'hFFFF_8001, 0, 0});
    vecs.push_back('{0, 3'b101, 32'h0000_5000, 32'h0,        32'h1234_F00D, 0, 1, 0, 3, 1, 4'b0011, 32'h0,        32'h0000_5000, 0, 32'h0000_F00D, 0, 0});
    vecs.push_back('{0, 3'b010, 32'h0000_6000, 32'h0,        32'h1234_5678, 0, 1, 0, 3, 1, 4'b1111, 32'h0,        32'h0000_6000, 0, 32'h1234_5678, 0, 0});
    vecs.push_back('{0, 3'b000, 32'h0000_7001, 32'h0,        32'h0000_7F00, 0, 1, 0, 3, 1, 4'b0010, 32'h0,        32'h0000_7000, 0, 32'h0000_007F, 0, 0});
    vecs.push_back('{1, 3'b000, 32'h0000_8001, 32'h1234_56A5, 32'h0,       0, 1, 0, 2, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0000_8000, 1, 32'h0,         0, 0});
    vecs.push_back('{1, 3'b010, 32'h0000_9000, 32'hCAFE_F00D, 32'h0,       3, 1, 0, 5, 4, 4'b1111, 32'hCAFE_F00D, 32'h0000_9000, 1, 32'h0,         0, 0});
    vecs.push_back('{1, 3'b010, 32'h0000_C000, 32'h1357_9BDF, 32'h0,       1, 1, 0, 3, 2, 4'b1111, 32'h1357_9BDF, 32'h0000_C000, 1, 32'h0,         0, 0});
    vecs.push_back('{0, 3'b001, 32'h0000_5001, 32'h0,        32'h0,        0, 1, 0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 32'h0,         1, 0});
    vecs.push_back('{1, 3'b001, 32'h0000_5003, 32'h0,        32'h0,        0, 1, 0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 32'h0,         1, 0});
    vecs.push_back('{1, 3'b010, 32'h0000_5002, 32'h0,        32'h0,        0, 1, 0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 32'h0,         1, 0});
    vecs.push_back('{1, 3'b100, 32'h0000_5000, 32'h0,        32'h0,        0, 1, 0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 32'h0,         1, 0});
    vecs.push_back('{0, 3'b110, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 0, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 32'h0,         1, 0});
    vecs.push_back('{0, 3'b010, 32'h0000_A000, 32'h0,        32'h5555_5555, 255, 1, 0, 5, 4, 4'b1111, 32'h0,      32'h0000_A000, 0, 32'h0,         0, 1});
    vecs.push_back('{0, 3'b010, 32'h0000_A004, 32'h0,        32'h5555_5555, 0, 0, 0, 6, 1, 4'b1111, 32'h0,        32'h0000_A004, 0, 32'h0,         0, 1});
    vecs.push_back('{0, 3'b010, 32'h0000_B000, 32'h0,        32'h0102_0304, 0, 1, 1, 3, 1, 4'b1111, 32'h0,        32'h0000_B000, 0, 32'h0102_0304, 0, 0});

    rst_n = 1'b0; op_valid = 1'b0; op_we = 1'b0; op_funct3 = 3'b0; op_addr = 32'h0; op_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_op_ready", {31'h0, op_ready}, 32'h1);
    check("rst_outputs", {27'h0, mem_req, done, err_align, err_bus, mem_be != 4'h0}, 32'h0);
    check("rst_ld_data", ld_data, 32'h0);

    for (int i = 0; i < vecs.size(); i++) run_op(i, vecs[i]);

    // Reset while waiting for read data: op is dropped without a done pulse.
    begin
      logic saw_done;
      saw_done = 1'b0;
      @(negedge clk);
      op_valid = 1'b1; op_we = 1'b0; op_funct3 = 3'b010; op_addr = 32'h0000_4000; op_wdata = 32'h0;
      @(posedge clk);
      #1 op_valid = 1'b0;
      @(negedge clk);
      check("rr_req", {31'h0, mem_req}, 32'h1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      check("rr_in_resp", {30'h0, mem_req, op_ready}, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      check("rr_async_idle", {30'h0, op_ready, mem_req}, 32'h2);
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      repeat (3) begin
        @(negedge clk);
        if (done) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      mem_rvalid = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (done || mem_req) saw_done = 1'b1;
      end
      check("rr_no_done", {31'h0, saw_done}, 32'h0);
      run_op(100, '{0, 3'b010, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, 3, 1, 4'b1111,
                     32'h0, 32'h0000_4000, 0, 32'hDEAD_BEEF, 0, 0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT, 255, maximum cycles waited for mem_gnt or mem_rvalid before bus error (range 1..255).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 op_valid  in  1  EX stage presents a memory op.
REQ-005 op_ready  out  1  LSU can accept an op this cycle.
REQ-006 op_we  in  1  1 = store, 0 = load.
REQ-007 op_funct3  in  3  RV32I load/store funct3.
REQ-008 op_addr  in  32  effective address (ALU ADD result).
REQ-009 op_wdata  in  32  store data (rs2).
REQ-010 mem_req  out  1  memory request, held until granted.
REQ-011 mem_gnt  in  1  memory accepts request this cycle.
REQ-012 mem_we / mem_addr / mem_wdata / mem_be  out  1/32/32/4  write enable, word address (addr[1:0]=00), lane-aligned data, byte enables.
REQ-013 mem_rvalid / mem_rdata  in  1/32  read data return.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 ld_data  out  32  extended load result, valid when done and load.
REQ-016 err_align / err_bus  out  1/1  misaligned-or-illegal / timeout error, valid with done.

Function
REQ-017 States IDLE, REQ, RESP, DONE; op_ready = 1 only in IDLE.
REQ-018 Op accepted on op_valid & op_ready; op_we, op_funct3, op_addr, op_wdata captured into registers at acceptance; later input changes ignored.
REQ-019 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all others illegal.
REQ-020 Halfword with addr[0]=1, word with addr[1:0]!=00, or illegal funct3: IDLE->DONE, no mem_req ever, err_align=1 at done.
REQ-021 Legal op: IDLE->REQ; mem_req=1 with stable mem_we/addr/wdata/be until mem_gnt sampled high.
REQ-022 REQ on mem_gnt: store -> DONE; load -> RESP.
REQ-023 RESP on mem_rvalid: capture extended data, -> DONE; mem_rvalid outside RESP ignored.
REQ-024 DONE: done=1 one cycle, then IDLE; minimum latency accept-to-done: 1 cycle misaligned, 2 store (gnt same cycle as entering REQ), 3 load (rvalid cycle after gnt).
REQ-025 Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; mem_wdata = byte/halfword replicated across lanes.
REQ-026 Load extraction: byte/halfword selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-027 8-bit wait counter cleared on entry to REQ and to RESP, +1 each cycle there without the awaited handshake; reaching TIMEOUT -> DONE with err_bus=1, ld_data=0, mem_req dropped.
REQ-028 mem_gnt and mem_rvalid both high in REQ: only gnt honoured; rvalid needed in a later cycle.
REQ-029 Error flags and ld_data = 0 whenever done = 0; err_align and err_bus never both 1.

Reset
REQ-030 rst_n low, any state, any time: state IDLE, counter 0, mem_req=0, done=0, err_align=0, err_bus=0, ld_data=0, mem_be=0, op_ready=1 after release; in-flight op discarded, no done pulse.

Verification
REQ-031 LB addr 0x1003, rvalid rdata 0x80112233 -> done, ld_data 0xFFFFFF80, mem_addr 0x1000; LBU same -> 0x00000080.
REQ-032 SH addr 0x2002, wdata 0x0000ABCD, gnt immediate -> mem_be 4'b1100, mem_wdata 0xABCDABCD, done 2 cycles after accept.
REQ-033 LW addr 0x3001 -> no mem_req, done next cycle with err_align=1; funct3 011 -> same.
REQ-034 TIMEOUT=4, load never granted -> mem_req high 4 cycles, then done with err_bus=1, ld_data 0.
REQ-035 rst_n asserted in RESP -> immediate IDLE, no done, next LW addr 0x4000 rdata 0xDEADBEEF returns 0xDEADBEEF.
